// File: rtl/matrix_mult_rect_if.sv
// Handshake and operand/result bus for matrix_mult_rect.
// The master drives start and the operands. The slave returns the result and status.
interface matrix_mult_rect_if #(
    parameter int unsigned ROWS_A = 2,
    parameter int unsigned INNER  = 2,
    parameter int unsigned COLS_B = 2,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 16
);
    logic                              start;
    logic [ROWS_A*INNER*IN_W-1:0]      a;
    logic [INNER*COLS_B*IN_W-1:0]      b;
    logic [ROWS_A*COLS_B*OUT_W-1:0]    c;
    logic                              busy;
    logic                              done;
    logic                              ovf;

    modport master (output start, a, b, input c, busy, done, ovf);
    modport slave  (input start, a, b, output c, busy, done, ovf);
endinterface

// File: rtl/matrix_mult_rect.sv
// Sequential signed matrix multiplier C = A x B (M x K by K x N).
// It performs one MAC per cycle and converts each result to OUT_W by saturating or wrapping.
module matrix_mult_rect #(
    parameter int unsigned ROWS_A = 2,
    parameter int unsigned INNER  = 2,
    parameter int unsigned COLS_B = 2,
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 16,
    parameter bit          SAT    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    matrix_mult_rect_if.slave   mm
);
    localparam int unsigned ProdW = 2 * IN_W;
    localparam int unsigned AccW  = 2 * IN_W + $clog2(INNER) + 1;
    localparam int unsigned IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
    localparam int unsigned JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam int unsigned KW    = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int unsigned AW    = ROWS_A * INNER * IN_W;
    localparam int unsigned BW    = INNER * COLS_B * IN_W;
    localparam int unsigned CW    = ROWS_A * COLS_B * OUT_W;
    localparam int unsigned AXW   = $clog2(AW);
    localparam int unsigned BXW   = $clog2(BW);
    localparam int unsigned CXW   = $clog2(CW);

    localparam logic [IW-1:0] LastI = IW'(ROWS_A - 1);
    localparam logic [JW-1:0] LastJ = JW'(COLS_B - 1);
    localparam logic [KW-1:0] LastK = KW'(INNER - 1);

    // OUT_W signed limits, sign-extended to accumulator width
    localparam logic signed [AccW-1:0] MaxVal = {{(AccW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AccW-1:0] MinVal = {{(AccW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                  state_q, state_d;
    logic [AW-1:0]           a_q, a_d;
    logic [BW-1:0]           b_q, b_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic [CW-1:0]           buf_q, buf_d;
    logic                    run_ovf_q, run_ovf_d;
    logic [CW-1:0]           c_q, c_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [AXW-1:0]          a_idx;
    logic [BXW-1:0]          b_idx;
    logic [CXW-1:0]          c_idx;
    logic signed [IN_W-1:0]  a_el, b_el;
    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  sum;
    logic                    oor;
    logic [OUT_W-1:0]        conv;

    always_comb begin
        a_idx = AXW'((32'(i_q) * INNER + 32'(k_q)) * IN_W);
        b_idx = BXW'((32'(k_q) * COLS_B + 32'(j_q)) * IN_W);
        c_idx = CXW'((32'(i_q) * COLS_B + 32'(j_q)) * OUT_W);
        a_el  = a_q[a_idx +: IN_W];
        b_el  = b_q[b_idx +: IN_W];
        prod  = ProdW'(a_el) * ProdW'(b_el);
        sum   = acc_q + AccW'(prod);
        oor   = (sum > MaxVal) || (sum < MinVal);
        if (oor && SAT) begin
            conv = (sum < 0) ? MinVal[OUT_W-1:0] : MaxVal[OUT_W-1:0];
        end else begin
            conv = sum[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        buf_d     = buf_q;
        run_ovf_d = run_ovf_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (mm.start) begin
                    a_d       = mm.a;
                    b_d       = mm.b;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    acc_d     = '0;
                    run_ovf_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StMac;
                end
            end
            StMac: begin
                busy_d = 1'b1;
                if (k_q == LastK) begin
                    buf_d[c_idx +: OUT_W] = conv;
                    acc_d     = '0;
                    k_d       = '0;
                    run_ovf_d = run_ovf_q | oor;
                    if (j_q == LastJ) begin
                        j_d = '0;
                        if (i_q == LastI) begin
                            // Exit edge: publish the whole buffer, including this element
                            i_d     = '0;
                            c_d     = buf_d;
                            ovf_d   = run_ovf_q | oor;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = StDone;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            buf_q     <= '0;
            run_ovf_q <= 1'b0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            buf_q     <= buf_d;
            run_ovf_q <= run_ovf_d;
            c_q       <= c_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mm.c    = c_q;
    assign mm.ovf  = ovf_q;
    assign mm.busy = busy_q;
    assign mm.done = done_q;
endmodule

// File: tb/tb_matrix_mult_rect.sv
// Directed bench for matrix_mult_rect. Several parameterisations share one clock and one reset.
module tb_matrix_mult_rect;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_mult_rect_if #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(16)) bus0 ();
    matrix_mult_rect_if #(.ROWS_A(2), .INNER(3), .COLS_B(1), .IN_W(8), .OUT_W(16)) bus1 ();
    matrix_mult_rect_if #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(8))  bus2 ();
    matrix_mult_rect_if #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(8))  bus3 ();
    matrix_mult_rect_if #(.ROWS_A(1), .INNER(1), .COLS_B(1), .IN_W(8), .OUT_W(16)) bus4 ();

    matrix_mult_rect #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(16), .SAT(1'b1))
        u0 (.clk(clk), .reset(reset), .mm(bus0));
    matrix_mult_rect #(.ROWS_A(2), .INNER(3), .COLS_B(1), .IN_W(8), .OUT_W(16), .SAT(1'b1))
        u1 (.clk(clk), .reset(reset), .mm(bus1));
    matrix_mult_rect #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(8), .SAT(1'b1))
        u2 (.clk(clk), .reset(reset), .mm(bus2));
    matrix_mult_rect #(.ROWS_A(2), .INNER(2), .COLS_B(2), .IN_W(8), .OUT_W(8), .SAT(1'b0))
        u3 (.clk(clk), .reset(reset), .mm(bus3));
    matrix_mult_rect #(.ROWS_A(1), .INNER(1), .COLS_B(1), .IN_W(8), .OUT_W(16), .SAT(1'b1))
        u4 (.clk(clk), .reset(reset), .mm(bus4));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic        ovf;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int w);
        case (w)
            0: return bus0.busy;
            1: return bus1.busy;
            2: return bus2.busy;
            3: return bus3.busy;
            default: return bus4.busy;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0: return bus0.done;
            1: return bus1.done;
            2: return bus2.done;
            3: return bus3.done;
            default: return bus4.done;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0: bus0.start = v;
            1: bus1.start = v;
            2: bus2.start = v;
            3: bus3.start = v;
            default: bus4.start = v;
        endcase
    endtask

    // Pulse start for one cycle. lat counts edges from the capture edge to the first cycle with done.
    // glitch counts cycles where busy/done disagree with the expected run profile.
    task automatic run(input int w, output int lat, output int glitch);
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        lat    = 0;
        glitch = busy_of(w) ? 0 : 1;
        while (!done_of(w) && lat < 50) begin
            @(negedge clk);
            lat++;
            if (busy_of(w) && done_of(w)) glitch++;
            else if (!busy_of(w) && !done_of(w)) glitch++;
        end
    endtask

    initial begin
        int          lat, gl, dcnt, dat, cchg;
        logic [63:0] res;

        vecs[0] = '{a: 32'h04030201, b: 32'h08070605, c: 64'h0032_002B_0016_0013, ovf: 1'b0};
        vecs[1] = '{a: 32'h01000001, b: 32'hFC0302FF, c: 64'hFFFC_0003_0002_FFFF, ovf: 1'b0};
        vecs[2] = '{a: 32'h80808080, b: 32'h80808080, c: 64'h7FFF_7FFF_7FFF_7FFF, ovf: 1'b1};
        vecs[3] = '{a: 32'h7F7F7F7F, b: 32'h80808080, c: 64'h8100_8100_8100_8100, ovf: 1'b0};
        vecs[4] = '{a: 32'h0500FD02, b: 32'h07FE0104, c: 64'h0023_FFF6_FFED_000E, ovf: 1'b0};

        bus0.start = 1'b0; bus0.a = '0; bus0.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
        bus3.start = 1'b0; bus3.a = '0; bus3.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_c",    64'(bus0.c), 64'h0);
        check("reset_busy", 64'(bus0.busy), 64'h0);
        check("reset_done", 64'(bus0.done), 64'h0);
        check("reset_ovf",  64'(bus0.ovf), 64'h0);

        for (int i = 0; i < 5; i++) begin
            bus0.a = vecs[i].a;
            bus0.b = vecs[i].b;
            run(0, lat, gl);
            check($sformatf("v%0d_c", i),       64'(bus0.c), vecs[i].c);
            check($sformatf("v%0d_ovf", i),     64'(bus0.ovf), 64'(vecs[i].ovf));
            check($sformatf("v%0d_lat", i),     64'(lat), 64'd8);
            check($sformatf("v%0d_profile", i), 64'(gl), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 64'(bus0.done), 64'h0);
        end

        // M=2, K=3, N=1
        bus1.a = 48'h060504030201;
        bus1.b = 24'h010101;
        run(1, lat, gl);
        check("rect_c",   64'(bus1.c), 64'h000F_0006);
        check("rect_lat", 64'(lat), 64'd6);
        check("rect_profile", 64'(gl), 64'd0);

        // OUT_W=8 saturate
        bus2.a = 32'h64646464;
        bus2.b = 32'h64646464;
        run(2, lat, gl);
        check("sat_pos_c",   64'(bus2.c), 64'h7F7F7F7F);
        check("sat_pos_ovf", 64'(bus2.ovf), 64'h1);
        bus2.a = 32'h80808080;
        bus2.b = 32'h7F7F7F7F;
        run(2, lat, gl);
        check("sat_neg_c",   64'(bus2.c), 64'h80808080);
        check("sat_neg_ovf", 64'(bus2.ovf), 64'h1);

        // OUT_W=8 wrap; 20000 = 0x4E20
        bus3.a = 32'h64646464;
        bus3.b = 32'h64646464;
        run(3, lat, gl);
        check("wrap_c",   64'(bus3.c), 64'h20202020);
        check("wrap_ovf", 64'(bus3.ovf), 64'h1);
        bus3.a = 32'h04030201;
        bus3.b = 32'h08070605;
        run(3, lat, gl);
        check("wrap_small_c",   64'(bus3.c), 64'h322B1613);
        check("wrap_small_ovf", 64'(bus3.ovf), 64'h0);

        // 1x1x1: done one cycle after the start edge
        bus4.a = 8'hFD;
        bus4.b = 8'h07;
        run(4, lat, gl);
        check("one_c",   64'(bus4.c), 64'hFFEB);
        check("one_lat", 64'(lat), 64'd1);

        // Start re-pulsed mid-run with new operands: ignored, C held until exit
        @(negedge clk);
        bus0.a = vecs[0].a;
        bus0.b = vecs[0].b;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        dcnt = 0; dat = -1; cchg = 0; res = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bus0.start = (n == 3 || n == 5);
            if (n == 3) begin
                bus0.a = 32'h11111111;
                bus0.b = 32'h22222222;
            end
            if (bus0.done) begin
                dcnt++;
                dat = n;
                res = 64'(bus0.c);
            end
            if (n < 8 && 64'(bus0.c) !== vecs[4].c) cchg++;
        end
        bus0.start = 1'b0;
        check("midstart_done_count", 64'(dcnt), 64'd1);
        check("midstart_done_at",    64'(dat), 64'd8);
        check("midstart_c",          res, vecs[0].c);
        check("midstart_c_held",     64'(cchg), 64'd0);

        // Reset at MAC cycle 4, then a fresh run
        @(negedge clk);
        bus0.a = vecs[4].a;
        bus0.b = vecs[4].b;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_c",    64'(bus0.c), 64'h0);
        check("rst_mid_busy", 64'(bus0.busy), 64'h0);
        check("rst_mid_done", 64'(bus0.done), 64'h0);
        check("rst_mid_ovf",  64'(bus0.ovf), 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_resume", 64'(bus0.busy), 64'h0);
        bus0.a = vecs[0].a;
        bus0.b = vecs[0].b;
        run(0, lat, gl);
        check("after_rst_c",   64'(bus0.c), vecs[0].c);
        check("after_rst_lat", 64'(lat), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
